// File: rtl/frame_pattern_gen.sv
// frame_pattern_gen: walks every page/column byte of the frame buffer once per start, emitting an animated pattern.
// Define FRAME_OVERRUN_CNT_EN to count (saturating) cycles where start arrives while a frame is in flight.
module frame_pattern_gen #(
  parameter int COLS   = 128,
  parameter int PAGES  = 8,
  parameter int ADDR_W = 10,
  parameter int STRIDE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        data_o,
  output logic              write_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [7:0]        overrun_cnt_o
);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [PW-1:0] PAGE_MAX = PW'(PAGES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d, phase_q, phase_d, rain_col;
  logic [PW-1:0] page_q, page_d;
  logic [1:0] mode_q, mode_d;
  logic accept, xfer, col_wrap, hit;
  assign accept   = state_q == IDLE && start_i;
  assign xfer     = state_q == RUN && wr_ready_i;
  assign col_wrap = col_q == COL_MAX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      page_q  <= '0;
      phase_q <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      page_q  <= page_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = accept ? RUN
            : (xfer && col_wrap && page_q == PAGE_MAX) ? DONE
            : state_q == DONE ? IDLE : state_q;
    mode_d  = accept ? mode_i : mode_q;
    col_d   = accept ? '0 : !xfer ? col_q : col_wrap ? '0 : col_q + 1'b1;
    page_d  = accept ? '0 : !(xfer && col_wrap) ? page_q
            : page_q == PAGE_MAX ? '0 : page_q + 1'b1;
    // interference mode scrolls the opposite way to the others
    phase_d = state_q != DONE ? phase_q
            : mode_q == 2'd2 ? (phase_q == '0 ? COL_MAX : phase_q - 1'b1)
            : (phase_q == COL_MAX ? '0 : phase_q + 1'b1);
  end

  always_comb begin
    rain_col     = phase_q + CW'(32'(page_q) * 32'(STRIDE));
    hit          = mode_q == 2'd0 ? col_q == phase_q
                 : mode_q == 2'd1 ? col_q == rain_col
                 : mode_q == 2'd2 ? (5'(col_q) * 5'(page_q) + 5'(phase_q)) >= 5'd16
                 : col_q[3] ^ page_q[0] ^ phase_q[0];
    write_o      = state_q == RUN;
    busy_o       = state_q != IDLE;
    frame_done_o = state_q == DONE;
    addr_o       = ADDR_W'({page_q, col_q});
    data_o       = write_o && hit ? 8'hFF : 8'h00;
  end

`ifdef FRAME_OVERRUN_CNT_EN
  logic [7:0] ovr_q, ovr_d;
  assign ovr_d = (start_i && busy_o && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= '0;
    else ovr_q <= ovr_d;
  end
  assign overrun_cnt_o = ovr_q;
`else
  assign overrun_cnt_o = 8'h00;
`endif
endmodule

// File: tb/tb_frame_pattern_gen.sv
// tb_frame_pattern_gen: frame vector table plus randomized frames, checked against a spec-level pattern model.
module tb_frame_pattern_gen;
  localparam int COLS = 128, PAGES = 8, ADDR_W = 10, STRIDE = 16, N = COLS * PAGES;
`ifdef FRAME_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, wr_ready_i = 1'b0;
  logic [1:0] mode_i = '0;
  logic [ADDR_W-1:0] addr_o;
  logic [7:0] data_o, overrun_cnt_o;
  logic write_o, busy_o, frame_done_o;
  int tests = 0, fails = 0, ph = 0, exp_ovr = 0;
  logic [7:0] got [N];

  typedef struct {
    logic [1:0] mode;
    bit         rst_before;
    int         stall_at;
    int         stall_len;
    bit         ovr;
    int         pa0;
    logic [7:0] pd0;
    int         pa1;
    logic [7:0] pd1;
  } vec_t;

  frame_pattern_gen #(.COLS(COLS), .PAGES(PAGES), .ADDR_W(ADDR_W), .STRIDE(STRIDE)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .wr_ready_i(wr_ready_i),
    .addr_o(addr_o), .data_o(data_o), .write_o(write_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .overrun_cnt_o(overrun_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int m, input int p, input int c, input int f);
    bit h;
    case (m)
      0:       h = c == f;
      1:       h = c == (f + p * STRIDE) % COLS;
      2:       h = (((c * p + f) % 256) / 16) % 2 == 1;
      default: h = ((c / 8) ^ p ^ f) % 2 == 1;
    endcase
    return h ? 8'hFF : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({addr_o, data_o, overrun_cnt_o, write_o, busy_o, frame_done_o});
  endfunction

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    start_i = 1'($urandom); mode_i = 2'($urandom); wr_ready_i = 1'($urandom);
    #1 check("async_rst", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1; start_i = 1'b0; ph = 0; exp_ovr = 0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst", all_outs(), 0);
    end
  endtask

  task automatic run_frame(input vec_t v, input bit rnd);
    int n = 0, k = 1, stalls = 0, held = 0;
    start_i = 1'b1; mode_i = v.mode; wr_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; mode_i = 2'($urandom);
    check("busy_start", 32'(busy_o), 1);
    while (!frame_done_o && k < 8 * N) begin
      start_i = v.ovr && (k == 100 || k == 200 || k == 300);
      if (start_i && busy_o && OVR_EN) exp_ovr++;
      check("write", 32'(write_o), 32'(n < N));
      if (write_o) begin
        check("addr", 32'(addr_o), 32'(n));
        check("data", 32'(data_o), 32'(pat(int'(v.mode), n / COLS, n % COLS, ph)));
        got[n] = data_o;
        if (n == v.stall_at && held < v.stall_len) begin
          wr_ready_i = 1'b0;
          held++;
        end else wr_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (wr_ready_i) n++;
        else stalls++;
      end
      @(negedge clk);
      k++;
    end
    start_i = 1'b0;
    check("done_lat", 32'(k), 32'(N + 1 + stalls));
    check("xfer_count", 32'(n), 32'(N));
    check("done_write", 32'(write_o), 0);
    check("done_busy", 32'(busy_o), 1);
    ph = v.mode == 2'd2 ? (ph + COLS - 1) % COLS : (ph + 1) % COLS;
    @(negedge clk);
    check("idle_after", 32'({busy_o, frame_done_o, write_o}), 0);
    check("overrun", 32'(overrun_cnt_o), 32'(exp_ovr));
    if (v.pa0 >= 0) check("probe0", 32'(got[v.pa0]), 32'(v.pd0));
    if (v.pa1 >= 0) check("probe1", 32'(got[v.pa1]), 32'(v.pd1));
  endtask

  initial begin
    vec_t tbl [7];
    vec_t r;
    tbl[0] = '{2'd0, 1'b0, -1, 0, 1'b0, 128, 8'hFF, 129, 8'h00};
    tbl[1] = '{2'd0, 1'b0, -1, 0, 1'b0, 129, 8'hFF, 128, 8'h00};
    tbl[2] = '{2'd1, 1'b0, 37, 5, 1'b0, 146, 8'hFF,   2, 8'hFF};
    tbl[3] = '{2'd3, 1'b0, -1, 0, 1'b1,   0, 8'hFF,   8, 8'h00};
    tbl[4] = '{2'd0, 1'b0, -1, 0, 1'b0,   0, 8'hFF,   1, 8'h00};
    tbl[5] = '{2'd2, 1'b1, -1, 0, 1'b0, 144, 8'hFF,   0, 8'h00};
    tbl[6] = '{2'd2, 1'b0, -1, 0, 1'b0, 389, 8'h00, 145, 8'hFF};
    start_i = 1'($urandom); mode_i = 2'($urandom); wr_ready_i = 1'($urandom);
    @(negedge clk);
    check("reset_outs", all_outs(), 0);
    rst_n = 1'b1; start_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_outs", all_outs(), 0);
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        start_i = 1'b1; mode_i = 2'd0; wr_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int t = 0; t < 2 * N && addr_o != 10'd500; t++) @(negedge clk);
        check("reach_500", 32'(addr_o), 500);
        reset_pulse();
      end
      if (tbl[i].rst_before) reset_pulse();
      run_frame(tbl[i], 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      r = '{2'($urandom), 1'b0, -1, 0, 1'($urandom), -1, 8'h00, -1, 8'h00};
      run_frame(r, 1'b1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/frame_pattern_gen.md
Name: frame_pattern_gen

Overview:
- Parametrised frame-buffer pattern writer for the OLED display path; successor to the single-pattern updater.
- On each frame trigger (e.g. the 30 Hz update request), it walks every page/column byte of the page-organised buffer once.
- Writes go out over a ready/valid write port with backpressure.
- Selectable pattern modes; a per-frame phase animates the pattern.
- Reports busy and frame-done status to the display controller.

Parameters:
- COLS, 128, columns per page (power of 2, ≥16)
- PAGES, 8, pages per frame (power of 2, ≥2)
- ADDR_W, 10, buffer address width; must be ≥ clog2(COLS*PAGES)
- STRIDE, 16, per-page column offset used by mode 1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame trigger; sampled only in IDLE
- mode  in  2  pattern select; latched at accepted start
- wr_ready  in  1  buffer accepts write this cycle
- addr  out  ADDR_W  buffer byte address
- data  out  8  buffer byte data
- write  out  1  write valid
- busy  out  1  high from accepted start through the DONE cycle
- frame_done  out  1  one-cycle pulse after the last byte transfers
- overrun_cnt  out  8  count of ignored starts (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; addr=0, data=0, write=0, busy=0, frame_done=0, overrun_cnt=0; page=0, col=0, phase=0, latched mode=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch mode; page=0, col=0; busy=1; go to RUN.
  - Next cycle: write=1, addr=0, data=pattern(0,0).
  - Latency is one cycle from start to first write.
- RUN:
  - addr = page*COLS + col.
  - A transfer occurs on a cycle where write=1 and wr_ready=1.
  - While write=1 and wr_ready=0, addr, data and write hold stable; no byte is skipped or repeated.
  - On transfer: col++. If col==COLS-1, col=0 and page++.
  - Transfer at page=PAGES-1, col=COLS-1: write=0 next cycle; go to DONE.
- DONE (one cycle):
  - frame_done=1.
  - phase update: mode 2 uses phase = (phase-1) mod COLS; other modes use phase = (phase+1) mod COLS.
  - Go to IDLE; busy=0 on the following cycle.
- Frame length with wr_ready held high: COLS*PAGES write cycles; frame_done asserts COLS*PAGES+1 cycles after start is sampled.
- Pattern, data = 8'hFF if the condition holds, else 8'h00:
  - mode 0 (vertical line): col == phase.
  - mode 1 (rain): col == (phase + page*STRIDE) mod COLS.
  - mode 2 (interference): bit 4 of ((col*page + phase) truncated to 8 bits) is 1.
  - mode 3 (checker): bit 0 of ((col>>3) ^ page ^ phase) is 1.
- start while busy (RUN or DONE): ignored, frame not restarted, and counted as an overrun.
- mode changes during RUN have no effect on the current frame.
- rst_n asserted mid-frame: immediate return to reset values; phase is lost; the next start begins at addr 0.
- Counters use exactly clog2(COLS) and clog2(PAGES) bits; wrap is explicit, never via overflow of wider registers.

Optional Feature:
- Macro: FRAME_OVERRUN_CNT_EN
- Defined:
  - overrun_cnt increments by 1 for every cycle with start=1 while busy=1.
  - Saturates at 8'hFF.
  - Cleared only by reset.
- Undefined: overrun_cnt is tied to 8'h00 and the counter logic is absent.
- Frame behaviour is identical either way.

Test Plan:
- Reset values: assert rst_n=0 mid-clock with random inputs → all outputs 0 asynchronously; after release, outputs stay 0 with start=0.
- Mode 0, wr_ready=1, single start:
  - exactly 1024 writes, addr 0..1023 in order.
  - data=FF only at addr p*128 (p=0..7).
  - frame_done pulse 1025 cycles after start is sampled.
  - second frame has FF at addr p*128+1.
- Backpressure: mode 1, drop wr_ready for 5 cycles when addr=37 → addr/data/write held for 5 cycles; 1024 unique transfers total; frame_done delayed by exactly 5 cycles.
- Mode 2 phase wrap:
  - after 1 frame from reset, phase=127.
  - frame-2 byte at page 3, col 5 → 00, since (15+127)=0x8E and bit 4=0.
  - byte at page 1, col 17 → FF, since (17+127)&0xFF=0x90 and bit 4=1.
- Overrun: pulse start 3 times during RUN → frame completes once, no restart; overrun_cnt=3 with FRAME_OVERRUN_CNT_EN, 0 without.
- Reset mid-frame: assert rst_n=0 at addr 500, release, then start → first write addr=0, and the mode 0 FF byte is at col 0 (phase reset).
